qsn_shift_pipe: RTL and testbench



---
 rtl/qsn_pkg.sv | 34 +++
 rtl/qsn_sel_decode.sv | 75 +++++++
 rtl/qsn_shift_pipe.sv | 189 ++++++++++++++++++
 tb/tb_qsn_shift_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsn_pkg.sv
// -----------------------------------------------------------------------------
// qsn_pkg
// Shared definitions for the quasi-cyclic shift network (QSN):
//   - QSN_Z_DEFAULT / QSN_Q_DEFAULT : lifting size and message width of the
//     default decoder build.
//   - qsn_clog2()                   : ceiling log2, used to size shift fields.
//   - `QSN_LANE(vec, j, q)          : selects message lane j (q bits wide) of a
//                                     lane-packed vector; used both to pack
//                                     and to unpack lanes.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef QSN_LANE
`define QSN_LANE(vec, j, q) vec[(j)*(q) +: (q)]
`endif

package qsn_pkg;

  localparam int QSN_Z_DEFAULT = 15;
  localparam int QSN_Q_DEFAULT = 3;

  // Smallest w with 2**w >= value (0 for value <= 1).
  function automatic int qsn_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/qsn_sel_decode.sv
// -----------------------------------------------------------------------------
// qsn_sel_decode
// Combinational decode of a (shift s, active size z) pair into the controls of
// the two-path cyclic shifter:
//   shift      in  SW    left cyclic shift s
//   zact       in  SW+1  active lifting size z
//   left_amt   out SW    amount for the "left" path (lanes j < z-s), = s
//   right_amt  out SW+1  amount for the "right" path (wrapped lanes), = z-s
//   merge_mask out Z-1   bit j-1 set iff lane j takes the left path; lane 0
//                        always takes it because z-s >= 1 on a legal beat
//   lane_mask  out Z     bit j set iff lane j < z
//   err        out 1     s >= z, z == 0 or z > Z
// An illegal pair drives all controls to zero; the datapath then zeroes the
// beat via err.
// -----------------------------------------------------------------------------
module qsn_sel_decode
  import qsn_pkg::*;
#(
  parameter int Z  = QSN_Z_DEFAULT,
  parameter int SW = qsn_clog2(Z)
) (
  input  logic [SW-1:0] shift,
  input  logic [SW:0]   zact,
  output logic [SW-1:0] left_amt,
  output logic [SW:0]   right_amt,
  output logic [Z-2:0]  merge_mask,
  output logic [Z-1:0]  lane_mask,
  output logic          err
);

  logic          err_s;
  logic [SW:0]   diff_s;

  assign diff_s = zact - {1'b0, shift};

  // Legality of the (s, z) pair.
  always_comb begin
    err_s = 1'b0;
    if (zact == {(SW+1){1'b0}}) begin
      err_s = 1'b1;
    end else if (zact > (SW+1)'(Z)) begin
      err_s = 1'b1;
    end else if ({1'b0, shift} >= zact) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Shift amounts and lane masks; neutral (all zero) for an illegal pair.
  always_comb begin
    left_amt   = '0;
    right_amt  = '0;
    merge_mask = '0;
    lane_mask  = '0;
    if (!err_s) begin
      left_amt  = shift;
      right_amt = diff_s;
      for (int j = 1; j < Z; j++) begin
        merge_mask[j-1] = ((SW+1)'(j) < diff_s);
      end
      for (int j = 0; j < Z; j++) begin
        lane_mask[j] = ((SW+1)'(j) < zact);
      end
    end else begin
      left_amt   = '0;
      right_amt  = '0;
      merge_mask = '0;
      lane_mask  = '0;
    end
  end

  assign err = err_s;

endmodule

// File: rtl/qsn_shift_pipe.sv
// -----------------------------------------------------------------------------
// qsn_shift_pipe
// Three-stage pipelined quasi-cyclic shift network. For z = in_zact and
// s = in_shift: out[j] = in[(j+s) mod z] for j < z, out[j] = 0 for j >= z.
// Illegal beats (s >= z, z == 0, z > Z) come out in order with out_err = 1 and
// all-zero data. All stages advance together (lock-step) when the output slot
// is empty or being consumed.
//   sys_clk   in  1     clock
//   rstn      in  1     synchronous active-low reset
//   in_valid  in  1     input beat valid
//   in_ready  out 1     input beat accepted this cycle
//   in_data   in  Z*Q   message j at in_data[j*Q +: Q]
//   in_shift  in  SW    left cyclic shift
//   in_zact   in  SW+1  active lifting size
//   out_valid out 1     output beat valid
//   out_ready in  1     downstream accepts
//   out_data  out Z*Q   shifted vector, same packing as in_data
//   out_err   out 1     beat carried an illegal shift or size
// -----------------------------------------------------------------------------
module qsn_shift_pipe
  import qsn_pkg::*;
#(
  parameter int Z  = QSN_Z_DEFAULT,
  parameter int Q  = QSN_Q_DEFAULT,
  parameter int SW = qsn_clog2(Z)
) (
  input  logic           sys_clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Z*Q-1:0] in_data,
  input  logic [SW-1:0]  in_shift,
  input  logic [SW:0]    in_zact,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Z*Q-1:0] out_data,
  output logic           out_err
);

  // Decoder outputs (S0 input side)
  logic [SW-1:0]         left_amt_s;
  logic [SW:0]           right_amt_s;
  logic [Z-2:0]          merge_mask_s;
  logic [Z-1:0]          lane_mask_s;
  logic                  err_s;
  logic                  adv_s;

  // S0 registers
  logic                  v0_r;
  logic [Z*Q-1:0]        d0_r;
  logic [SW-1:0]         lsh0_r;
  logic [SW:0]           rsh0_r;
  logic [Z-2:0]          mask0_r;
  logic [Z-1:0]          zmask0_r;
  logic                  err0_r;

  // S1 shift results per bit-plane and registers
  logic [Q-1:0][Z-1:0]   left_s;
  logic [Q-1:0][Z-1:0]   right_s;
  logic                  v1_r;
  logic [Q-1:0][Z-1:0]   left1_r;
  logic [Q-1:0][Z-1:0]   right1_r;
  logic [Z-2:0]          mask1_r;
  logic                  err1_r;

  // S2 merge and output registers
  logic [Z-1:0]          sel_s;
  logic [Z*Q-1:0]        merged_s;
  logic                  out_valid_r;
  logic [Z*Q-1:0]        out_data_r;
  logic                  out_err_r;

  assign adv_s    = !out_valid_r || out_ready;
  assign in_ready = adv_s;

  qsn_sel_decode #(
    .Z  (Z),
    .SW (SW)
  ) u_sel_decode (
    .shift      (in_shift),
    .zact       (in_zact),
    .left_amt   (left_amt_s),
    .right_amt  (right_amt_s),
    .merge_mask (merge_mask_s),
    .lane_mask  (lane_mask_s),
    .err        (err_s)
  );

  // S0: capture the beat and its decoded shift controls.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      v0_r     <= 1'b0;
      d0_r     <= '0;
      lsh0_r   <= '0;
      rsh0_r   <= '0;
      mask0_r  <= '0;
      zmask0_r <= '0;
      err0_r   <= 1'b0;
    end else if (adv_s) begin
      v0_r <= in_valid;
      if (in_valid) begin
        d0_r     <= in_data;
        lsh0_r   <= left_amt_s;
        rsh0_r   <= right_amt_s;
        mask0_r  <= merge_mask_s;
        zmask0_r <= lane_mask_s;
        err0_r   <= err_s;
      end
    end
  end

  // One Z-wide barrel shift pair per bit-plane. Lanes >= z are cleared before
  // shifting so nothing outside the active ring leaks in; the wrapped path is
  // cleared again afterwards because it can land on lanes >= z.
  for (genvar b = 0; b < Q; b++) begin : g_plane
    logic [Z-1:0] plane_s;

    // Gather bit b of every active lane into one plane.
    always_comb begin
      plane_s = '0;
      for (int j = 0; j < Z; j++) begin
        plane_s[j] = d0_r[j*Q + b] & zmask0_r[j];
      end
    end

    assign left_s[b]  = plane_s >> lsh0_r;
    assign right_s[b] = (plane_s << rsh0_r) & zmask0_r;
  end

  // S1: register both shift paths together with the merge controls.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      v1_r     <= 1'b0;
      left1_r  <= '0;
      right1_r <= '0;
      mask1_r  <= '0;
      err1_r   <= 1'b0;
    end else if (adv_s) begin
      v1_r     <= v0_r;
      left1_r  <= left_s;
      right1_r <= right_s;
      mask1_r  <= mask0_r;
      err1_r   <= err0_r;
    end
  end

  // Lane 0 always takes the left path; the stored mask covers lanes 1..Z-1.
  assign sel_s = {mask1_r, 1'b1};

  // Merge the two paths lane by lane and repack; an illegal beat is zeroed.
  always_comb begin
    merged_s = '0;
    for (int j = 0; j < Z; j++) begin
      logic [Q-1:0] lane_s;
      lane_s = '0;
      for (int b = 0; b < Q; b++) begin
        if (sel_s[j]) begin
          lane_s[b] = left1_r[b][j];
        end else begin
          lane_s[b] = right1_r[b][j];
        end
      end
      `QSN_LANE(merged_s, j, Q) = lane_s;
    end
    if (err1_r) begin
      merged_s = '0;
    end else begin
      merged_s = merged_s;
    end
  end

  // S2: output register.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_err_r   <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= v1_r;
      out_data_r  <= merged_s;
      out_err_r   <= v1_r & err1_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_qsn_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_qsn_shift_pipe
// Self-checking bench for qsn_shift_pipe (Z=15, Q=3). A queue-based model
// computes each accepted beat's result with plain modular arithmetic; one
// negedge process compares every valid output beat against the queue head.
// Directed tests add hand-computed lane values, latency, stall, and reset
// checks; a randomized phase exercises random s/z and backpressure.
// -----------------------------------------------------------------------------
module tb_qsn_shift_pipe;

  localparam int Z  = 15;
  localparam int Q  = 3;
  localparam int SW = 4;
  localparam int ZQ = Z * Q;

  logic          sys_clk   = 1'b0;
  logic          rstn      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [ZQ-1:0] in_data   = '0;
  logic [SW-1:0] in_shift  = '0;
  logic [SW:0]   in_zact   = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [ZQ-1:0] out_data;
  logic          out_err;

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [ZQ:0] exp_q[$];
  int exp_lanes [Z];
  bit rdy_run;

  qsn_shift_pipe #(.Z(Z), .Q(Q)) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_zact   (in_zact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [ZQ:0] act, input logic [ZQ:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {err, data} for one beat, straight from the rotation rule.
  function automatic logic [ZQ:0] model(input logic [ZQ-1:0] d, input int s, input int z);
    logic [ZQ-1:0] o;
    o = '0;
    if (z < 1 || z > Z || s >= z) return {1'b1, {ZQ{1'b0}}};
    for (int j = 0; j < z; j++) o[j*Q +: Q] = d[((j + s) % z)*Q +: Q];
    return {1'b0, o};
  endfunction

  function automatic logic [ZQ-1:0] pat(input int k);
    logic [ZQ-1:0] v;
    v = '0;
    for (int j = 0; j < Z; j++) v[j*Q +: Q] = Q'((j + k) % 8);
    return v;
  endfunction

  function automatic logic [ZQ-1:0] rnd_data();
    logic [ZQ-1:0] v;
    v = '0;
    for (int j = 0; j < Z; j++) v[j*Q +: Q] = Q'($urandom_range(0, 7));
    return v;
  endfunction

  // Scoreboard: compare every valid output, pop on handshake, push on accept.
  always @(negedge sys_clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_valid, 1'b0);
        end else begin
          chk("sb_data", out_data, exp_q[0][ZQ-1:0]);
          chk("sb_err", out_err, exp_q[0][ZQ]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pop_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, int'(in_shift), int'(in_zact)));
        acc_cnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive(input logic [ZQ-1:0] d, input int s, input int z);
    int budget;
    budget   = 200;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = SW'(s);
    in_zact  = (SW+1)'(z);
    @(negedge sys_clk);
    while (!in_ready && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    if (budget == 0) chk("drive_timeout", in_ready, 1'b1);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int budget;
    budget = 60;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    chk(name, exp_q.size(), 0);
    @(posedge sys_clk); #1;
  endtask

  // Single beat on an empty pipe: exact 3-cycle latency plus literal lanes.
  task automatic lat_test(input logic [ZQ-1:0] d, input int s, input int z, input logic err);
    drive(d, s, z);
    @(posedge sys_clk); @(negedge sys_clk);
    chk("latency_early", out_valid, 1'b0);
    @(posedge sys_clk); @(negedge sys_clk);
    chk("latency_3", out_valid, 1'b1);
    chk("lit_err", out_err, err);
    for (int j = 0; j < Z; j++)
      chk($sformatf("lit_lane%0d", j), out_data[j*Q +: Q], exp_lanes[j][Q-1:0]);
    @(posedge sys_clk); #1;
  endtask

  initial begin
    logic [ZQ:0] m;
    int base, pbase;

    // Pin the model itself on hand-computed lanes (s=1, z=15, lane j = j mod 8).
    m = model(pat(0), 1, 15);
    chk("model_pin_lane6", m[6*Q +: Q], 7);
    chk("model_pin_lane14", m[14*Q +: Q], 0);
    chk("model_pin_err", m[ZQ], 1'b0);

    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_err", out_err, 1'b0);
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    @(negedge sys_clk);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge sys_clk); #1;

    // s=1, z=15
    exp_lanes = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 0};
    lat_test(pat(0), 1, 15, 1'b0);
    // s=3, z=7
    exp_lanes = '{3, 4, 5, 6, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    lat_test(pat(0), 3, 7, 1'b0);
    // z=Z, s=0 is identity
    exp_lanes = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6};
    lat_test(pat(0), 0, 15, 1'b0);

    // Illegal s=15 followed back-to-back by identity
    drive(pat(1), 15, 15);
    drive(pat(1), 0, 15);
    @(negedge sys_clk);
    @(posedge sys_clk); @(negedge sys_clk);
    chk("illegal_valid", out_valid, 1'b1);
    chk("illegal_err", out_err, 1'b1);
    chk("illegal_data", out_data, '0);
    @(negedge sys_clk);
    chk("ident_valid", out_valid, 1'b1);
    chk("ident_err", out_err, 1'b0);
    chk("ident_data", out_data, pat(1));
    @(posedge sys_clk); #1;
    // Other illegal sizes go through the scoreboard
    drive(pat(2), 0, 0);
    drive(pat(2), 1, 16);
    drive(pat(2), 5, 5);
    wait_empty("illegal_drain");

    // Backpressure: 5 beats with out_ready low
    out_ready = 1'b0;
    base  = acc_cnt;
    pbase = pop_cnt;
    fork
      begin
        for (int k = 1; k <= 5; k++) drive(pat(k), k, 15);
      end
      begin
        repeat (6) @(negedge sys_clk);
        chk("stall_accepted", acc_cnt - base, 3);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_hold_beat1", {out_err, out_data}, model(pat(1), 1, 15));
        @(posedge sys_clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_empty("stall_drain");
    chk("stall_pops", pop_cnt - pbase, 5);

    // Reset with two beats in flight
    drive(pat(2), 4, 15);
    drive(pat(3), 5, 12);
    rstn = 1'b0;
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    @(negedge sys_clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_err", out_err, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (5) begin
      @(negedge sys_clk);
      chk("midrst_no_stale", out_valid, 1'b0);
    end
    @(posedge sys_clk); #1;

    // Randomized shifts, sizes and backpressure
    rdy_run = 1'b1;
    fork
      begin
        for (int n = 0; n < 3000; n++) begin
          int z, s;
          if ($urandom_range(0, 9) == 0) z = $urandom_range(0, 31);
          else z = $urandom_range(1, 15);
          if ($urandom_range(0, 9) == 0 || z == 0) s = $urandom_range(0, 15);
          else s = $urandom_range(0, (z > 15) ? 15 : z - 1);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge sys_clk); #1;
          end
          drive(rnd_data(), s, z);
        end
        rdy_run = 1'b0;
      end
      begin
        while (rdy_run) begin
          @(posedge sys_clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
